// File: rtl/alu_sequencer_if.sv
// Control/status bundle between the multicycle sequencer (master) and the
// datapath plus instruction register (slave).
interface alu_sequencer_if;
    logic [31:0] instr;
    logic        alu_flags;
    logic [1:0]  alu_control;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  reg_src;
    logic [1:0]  imm_src;
    logic        z_flag;

    modport master (
        input  instr, alu_flags,
        output alu_control, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, reg_src, imm_src, z_flag
    );

    modport slave (
        output instr, alu_flags,
        input  alu_control, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, reg_src, imm_src, z_flag
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute, holds Z.
// Build option: define ALU_SEQ_CMP_EN to make cmd 1010 (CMP) a legal flag-setting op.
module alu_sequencer (
    input  logic             clk,
    input  logic             reset,
    alu_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
        EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    typedef struct packed {
        logic [1:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = ctrl_t'(13'd0);
    localparam ctrl_t CTRL_FETCH = '{alu_control: 2'b00, alu_src_a: 1'b1, alu_src_b: 2'b10,
                                     result_src: 2'b10, adr_src: 1'b0, ir_write: 1'b1,
                                     pc_write: 1'b1, reg_write: 1'b0, mem_write: 1'b0};

    state_t      state_r, next_state_s;
    ctrl_t       ctrl_r, ctrl_next_s, ctrl_out_s;
    logic        z_flag_r;
    logic        cond_ex_s, legal_s, is_cmp_s, s_eff_s, write_ok_s, rd_pc_s;
    logic [1:0]  alu_dec_s;
    logic [1:0]  op_s;
    logic [3:0]  cmd_s;
    logic        unused_bits_s;

    assign op_s          = bus.instr[27:26];
    assign cmd_s         = bus.instr[24:21];
    assign rd_pc_s       = (bus.instr[15:12] == 4'd15);
    assign s_eff_s       = bus.instr[20] | is_cmp_s;
    assign write_ok_s    = legal_s & ~is_cmp_s;
    assign unused_bits_s = ^{bus.instr[19:16], bus.instr[11:0]};

    // Condition-code evaluation against the current architectural Z.
    always_comb begin
        cond_ex_s = 1'b0;
        case (bus.instr[31:28])
            4'b0000: cond_ex_s = z_flag_r;
            4'b0001: cond_ex_s = ~z_flag_r;
            4'b1110: cond_ex_s = 1'b1;
            default: cond_ex_s = 1'b0;
        endcase
    end

    // Data-processing command decode; unknown commands fall back to a harmless add.
    always_comb begin
        alu_dec_s = 2'b00;
        legal_s   = 1'b0;
        is_cmp_s  = 1'b0;
        case (cmd_s)
            4'b0100: begin alu_dec_s = 2'b00; legal_s = 1'b1; end
            4'b0010: begin alu_dec_s = 2'b01; legal_s = 1'b1; end
            4'b0000: begin alu_dec_s = 2'b10; legal_s = 1'b1; end
            4'b1101: begin alu_dec_s = 2'b11; legal_s = 1'b1; end
`ifdef ALU_SEQ_CMP_EN
            4'b1010: begin alu_dec_s = 2'b01; legal_s = 1'b1; is_cmp_s = 1'b1; end
`endif
            default: begin alu_dec_s = 2'b00; legal_s = 1'b0; end
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH:    next_state_s = DECODE;
            DECODE: begin
                case (op_s)
                    2'b01:   next_state_s = MEMADR;
                    2'b00:   next_state_s = bus.instr[25] ? EXECUTEI : EXECUTER;
                    2'b10:   next_state_s = BRANCH;
                    default: next_state_s = FETCH;
                endcase
            end
            MEMADR:   next_state_s = bus.instr[20] ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state_s = MEMWB;
            EXECUTER: next_state_s = ALUWB;
            EXECUTEI: next_state_s = ALUWB;
            default:  next_state_s = FETCH;
        endcase
    end

    // Controls for the state being entered; condition gating sees Z before any update on this edge.
    always_comb begin
        ctrl_next_s = CTRL_IDLE;
        case (next_state_s)
            FETCH: ctrl_next_s = CTRL_FETCH;
            DECODE: begin
                ctrl_next_s.alu_src_a  = 1'b1;
                ctrl_next_s.alu_src_b  = 2'b10;
                ctrl_next_s.result_src = 2'b10;
            end
            MEMADR:  ctrl_next_s.alu_src_b = 2'b01;
            MEMREAD: ctrl_next_s.adr_src   = 1'b1;
            MEMWRITE: begin
                ctrl_next_s.adr_src   = 1'b1;
                ctrl_next_s.mem_write = cond_ex_s;
            end
            MEMWB: begin
                ctrl_next_s.result_src = 2'b01;
                ctrl_next_s.reg_write  = cond_ex_s;
                ctrl_next_s.pc_write   = cond_ex_s & rd_pc_s;
            end
            EXECUTER: ctrl_next_s.alu_control = alu_dec_s;
            EXECUTEI: begin
                ctrl_next_s.alu_control = alu_dec_s;
                ctrl_next_s.alu_src_b   = 2'b01;
            end
            ALUWB: begin
                ctrl_next_s.reg_write = cond_ex_s & write_ok_s;
                ctrl_next_s.pc_write  = cond_ex_s & write_ok_s & rd_pc_s;
            end
            BRANCH: begin
                ctrl_next_s.alu_src_b  = 2'b01;
                ctrl_next_s.result_src = 2'b10;
                ctrl_next_s.pc_write   = cond_ex_s;
            end
            default: ctrl_next_s = CTRL_IDLE;
        endcase
    end

    // State, registered controls and architectural Z flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= FETCH;
            ctrl_r   <= CTRL_FETCH;
            z_flag_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_next_s;
            if (((state_r == EXECUTER) || (state_r == EXECUTEI)) && cond_ex_s && s_eff_s && legal_s) begin
                z_flag_r <= bus.alu_flags;
            end else begin
                z_flag_r <= z_flag_r;
            end
        end
    end

    // Reset forces every strobe and select low in the same cycle it is asserted.
    assign ctrl_out_s      = reset ? CTRL_IDLE : ctrl_r;
    assign bus.alu_control = ctrl_out_s.alu_control;
    assign bus.alu_src_a   = ctrl_out_s.alu_src_a;
    assign bus.alu_src_b   = ctrl_out_s.alu_src_b;
    assign bus.result_src  = ctrl_out_s.result_src;
    assign bus.adr_src     = ctrl_out_s.adr_src;
    assign bus.ir_write    = ctrl_out_s.ir_write;
    assign bus.pc_write    = ctrl_out_s.pc_write;
    assign bus.reg_write   = ctrl_out_s.reg_write;
    assign bus.mem_write   = ctrl_out_s.mem_write;
    assign bus.reg_src     = reset ? 2'b00 : {(op_s == 2'b01), (op_s == 2'b10)};
    assign bus.imm_src     = reset ? 2'b00 : op_s;
    assign bus.z_flag      = z_flag_r;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed per-cycle vector bench for alu_sequencer.
module tb_alu_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word: {alu_control, src_a, src_b, result_src, adr_src, ir, pc, reg, mem}
    localparam logic [12:0] C_FETCH  = {2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [12:0] C_DECODE = {2'b00, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [12:0] C_MEMADR = {2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [12:0] C_MEMRD  = {2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [12:0] C_MEMWRY = {2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [12:0] C_MEMWB  = {2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [12:0] C_EXI_SUB= {2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [12:0] C_ALUWB_W= {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [12:0] C_BR_T   = {2'b00, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [12:0] C_BR_N   = {2'b00, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [12:0] C_ZERO   = 13'd0;
`ifdef ALU_SEQ_CMP_EN
    localparam logic [12:0] C_EXR_1010 = {2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic        Z_CMP      = 1'b1;
`else
    localparam logic [12:0] C_EXR_1010 = 13'd0;
    localparam logic        Z_CMP      = 1'b0;
`endif

    localparam logic [31:0] I_ADD   = 32'hE0812003;
    localparam logic [31:0] I_SUBS  = 32'hE2523001;
    localparam logic [31:0] I_BEQ   = 32'h0A000002;
    localparam logic [31:0] I_BNE   = 32'h1A000002;
    localparam logic [31:0] I_LDR   = 32'hE5912000;
    localparam logic [31:0] I_STREQ = 32'h05812000;
    localparam logic [31:0] I_STRAL = 32'hE5812000;
    localparam logic [31:0] I_1010  = 32'hE1510002;
    localparam logic [31:0] I_OP11  = 32'hEC000000;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        flags;
        logic [12:0] ctl;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(string name, logic [31:0] instr, logic flags,
                                    logic [12:0] ctl, logic z);
        vec_t v;
        v.name  = name;
        v.instr = instr;
        v.flags = flags;
        v.ctl   = ctl;
        v.z     = z;
        vecs.push_back(v);
    endfunction

    function automatic logic [12:0] act_ctl();
        return {bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.adr_src,
                bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.instr     = 32'd0;
        bus.alu_flags = 1'b0;

        // ADD register form, S=0: flags offered but Z must not move
        add_vec("add_fetch",  I_ADD, 1'b0, C_FETCH,   1'b0);
        add_vec("add_decode", I_ADD, 1'b0, C_DECODE,  1'b0);
        add_vec("add_exr",    I_ADD, 1'b1, C_ZERO,    1'b0);
        add_vec("add_aluwb",  I_ADD, 1'b0, C_ALUWB_W, 1'b0);
        // STR EQ with Z=0: no write, 4 cycles
        add_vec("streq_fetch",  I_STREQ, 1'b0, C_FETCH,  1'b0);
        add_vec("streq_decode", I_STREQ, 1'b0, C_DECODE, 1'b0);
        add_vec("streq_memadr", I_STREQ, 1'b0, C_MEMADR, 1'b0);
        add_vec("streq_memwr",  I_STREQ, 1'b0, C_MEMRD,  1'b0);
        // STR AL: write fires
        add_vec("stral_fetch",  I_STRAL, 1'b0, C_FETCH,  1'b0);
        add_vec("stral_decode", I_STRAL, 1'b0, C_DECODE, 1'b0);
        add_vec("stral_memadr", I_STRAL, 1'b0, C_MEMADR, 1'b0);
        add_vec("stral_memwr",  I_STRAL, 1'b0, C_MEMWRY, 1'b0);
        // cmd 1010 with S=1, ALU reports zero
        add_vec("c1010_fetch",  I_1010, 1'b0, C_FETCH,    1'b0);
        add_vec("c1010_decode", I_1010, 1'b0, C_DECODE,   1'b0);
        add_vec("c1010_exr",    I_1010, 1'b1, C_EXR_1010, 1'b0);
        add_vec("c1010_aluwb",  I_1010, 1'b0, C_ZERO,     Z_CMP);
        // SUBS immediate, ALU reports zero
        add_vec("subs_fetch",  I_SUBS, 1'b0, C_FETCH,   Z_CMP);
        add_vec("subs_decode", I_SUBS, 1'b0, C_DECODE,  Z_CMP);
        add_vec("subs_exi",    I_SUBS, 1'b1, C_EXI_SUB, Z_CMP);
        add_vec("subs_aluwb",  I_SUBS, 1'b0, C_ALUWB_W, 1'b1);
        // BEQ taken, BNE not taken, 3 cycles each
        add_vec("beq_fetch",  I_BEQ, 1'b0, C_FETCH,  1'b1);
        add_vec("beq_decode", I_BEQ, 1'b0, C_DECODE, 1'b1);
        add_vec("beq_branch", I_BEQ, 1'b0, C_BR_T,   1'b1);
        add_vec("bne_fetch",  I_BNE, 1'b0, C_FETCH,  1'b1);
        add_vec("bne_decode", I_BNE, 1'b0, C_DECODE, 1'b1);
        add_vec("bne_branch", I_BNE, 1'b0, C_BR_N,   1'b1);
        // LDR: 5 cycles
        add_vec("ldr_fetch",  I_LDR, 1'b0, C_FETCH,  1'b1);
        add_vec("ldr_decode", I_LDR, 1'b0, C_DECODE, 1'b1);
        add_vec("ldr_memadr", I_LDR, 1'b0, C_MEMADR, 1'b1);
        add_vec("ldr_memrd",  I_LDR, 1'b0, C_MEMRD,  1'b1);
        add_vec("ldr_memwb",  I_LDR, 1'b0, C_MEMWB,  1'b1);
        // Op=11: straight back to FETCH
        add_vec("op11_fetch",  I_OP11, 1'b0, C_FETCH,  1'b1);
        add_vec("op11_decode", I_OP11, 1'b0, C_DECODE, 1'b1);
        // LDR that will be reset in MEMREAD
        add_vec("ldr2_fetch",  I_LDR, 1'b0, C_FETCH,  1'b1);
        add_vec("ldr2_decode", I_LDR, 1'b0, C_DECODE, 1'b1);
        add_vec("ldr2_memadr", I_LDR, 1'b0, C_MEMADR, 1'b1);

        // Initial reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {19'd0, act_ctl()}, {19'd0, C_ZERO});
        check("reset_z", {31'd0, bus.z_flag}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.instr     = vecs[i].instr;
            bus.alu_flags = vecs[i].flags;
            op = vecs[i].instr[27:26];
            @(negedge clk);
            check(vecs[i].name, {19'd0, act_ctl()}, {19'd0, vecs[i].ctl});
            check({vecs[i].name, "_z"}, {31'd0, bus.z_flag}, {31'd0, vecs[i].z});
            check({vecs[i].name, "_src"}, {28'd0, bus.reg_src, bus.imm_src},
                  {28'd0, (op == 2'b01), (op == 2'b10), op});
            @(posedge clk);
            #1;
        end

        // Now in MEMREAD of the second LDR: reset for two cycles
        reset = 1'b1;
        @(negedge clk);
        check("rst_memrd_ctl", {19'd0, act_ctl()}, {19'd0, C_ZERO});
        check("rst_memrd_src", {28'd0, bus.reg_src, bus.imm_src}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst2_ctl", {19'd0, act_ctl()}, {19'd0, C_ZERO});
        check("rst2_z", {31'd0, bus.z_flag}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", {19'd0, act_ctl()}, {19'd0, C_FETCH});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_decode", {19'd0, act_ctl()}, {19'd0, C_DECODE});
        check("post_rst_z", {31'd0, bus.z_flag}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
